// File: rtl/gbe_rx_pkg.sv
// Shared types and constants for the GbE receive application packer.
package gbe_rx_pkg;

  localparam int unsigned LANES        = 8;
  localparam int unsigned IDX_W        = 3;
  localparam int unsigned WORD_W       = 64;
  localparam int unsigned HDR_IP_LSB   = 0;
  localparam int unsigned HDR_PORT_LSB = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    COLLECT = 2'd2,
    HOLD    = 2'd3
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [LANES-1:0]  keep;
    logic              last;
    logic              err;
  } word_t;

  // Header word layout: {16'h0, srcport, srcip}
  function automatic word_t hdr_word(input logic [31:0] ip, input logic [15:0] port);
    word_t w;
    w = '0;
    w.data[HDR_IP_LSB +: 32]   = ip;
    w.data[HDR_PORT_LSB +: 16] = port;
    w.keep                     = '1;
    return w;
  endfunction

endpackage

// File: rtl/gbe_rx_app_packer_if.sv
// Byte-wide receive-core bus and 64-bit packed word bus used by the packer.
interface gbe_rx_byte_if;
  logic [7:0]  app_rx_data;
  logic        app_rx_dvld;
  logic        app_rx_eof;
  logic [31:0] app_rx_srcip;
  logic [15:0] app_rx_srcport;
  logic        app_rx_badframe;
  logic        app_rx_overrun;
  logic        app_rx_ack;
  logic        app_rx_rst;

  modport master (output app_rx_data, app_rx_dvld, app_rx_eof, app_rx_srcip, app_rx_srcport,
                         app_rx_badframe, app_rx_overrun,
                  input  app_rx_ack, app_rx_rst);
  modport slave  (input  app_rx_data, app_rx_dvld, app_rx_eof, app_rx_srcip, app_rx_srcport,
                         app_rx_badframe, app_rx_overrun,
                  output app_rx_ack, app_rx_rst);
endinterface

interface gbe_rx_word_if;
  logic [63:0] out_data;
  logic [7:0]  out_keep;
  logic        out_valid;
  logic        out_last;
  logic        out_err;
  logic [31:0] out_srcip;
  logic [15:0] out_srcport;
  logic        out_ready;

  modport master (output out_data, out_keep, out_valid, out_last, out_err, out_srcip, out_srcport,
                  input  out_ready);
  modport slave  (input  out_data, out_keep, out_valid, out_last, out_err, out_srcip, out_srcport,
                  output out_ready);
endinterface

// File: rtl/gbe_rx_stat_cnt.sv
// Statistics counter: wraps by default, saturates at all-ones when SAT is set.
module gbe_rx_stat_cnt #(
  parameter int unsigned W   = 32,
  parameter bit          SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && !(SAT && (&cnt))) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/gbe_rx_app_packer.sv
// Packs the byte-wide UDP receive stream into 64-bit words with keep/last/err and statistics.
// Optional header word per frame when RX_PACKER_HDR_EN is defined.
module gbe_rx_app_packer
  import gbe_rx_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned OVR_W = 16
) (
  input  logic             app_clk,
  input  logic             app_rst_n,
  gbe_rx_byte_if.slave     rx,
  gbe_rx_word_if.master    ow,
  input  logic             sw_flush,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt,
  output logic [OVR_W-1:0] ovr_cnt
);

  state_t           state;
  word_t            acc;
  word_t            nxt;
  word_t            out_q;
  word_t            load_word;
  logic [IDX_W-1:0] idx;
  logic             acc_full;
  logic             out_vld;
  logic [31:0]      frame_ip;
  logic [15:0]      frame_port;
  logic [31:0]      out_ip;
  logic [15:0]      out_port;
  logic             out_free;
  logic             take;
  logic             word_done;
  logic             load_en;
  logic             rx_rst_q;
  logic             flush_left;
  logic             ovr_prev;

  assign out_free   = !out_vld || ow.out_ready;
  assign take       = rx.app_rx_dvld && (state == COLLECT) && !acc_full;
  assign word_done  = (idx == IDX_W'(LANES - 1)) || rx.app_rx_eof;
  assign rx.app_rx_ack = take;
  assign rx.app_rx_rst = rx_rst_q;

  // Accumulator with the incoming byte merged into lane idx
  always_comb begin
    nxt                          = acc;
    nxt.data[{idx, 3'b000} +: 8] = rx.app_rx_data;
    nxt.keep[idx]                = 1'b1;
    nxt.last                     = rx.app_rx_eof;
    nxt.err                      = rx.app_rx_eof & rx.app_rx_badframe;
  end

  // Selects what, if anything, moves into the output register this cycle
  always_comb begin
    load_en   = 1'b0;
    load_word = nxt;
    case (state)
`ifdef RX_PACKER_HDR_EN
      HDR: begin
        load_en   = out_free;
        load_word = hdr_word(frame_ip, frame_port);
      end
`endif
      COLLECT: load_en = take && word_done && out_free;
      HOLD: begin
        load_en   = out_free;
        load_word = acc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge app_clk) begin
    if (!app_rst_n || sw_flush) begin
      state      <= IDLE;
      acc        <= '0;
      idx        <= '0;
      acc_full   <= 1'b0;
      out_q      <= '0;
      out_vld    <= 1'b0;
      out_ip     <= '0;
      out_port   <= '0;
      frame_ip   <= '0;
      frame_port <= '0;
    end else begin
      if (load_en) begin
        out_q    <= load_word;
        out_vld  <= 1'b1;
        out_ip   <= frame_ip;
        out_port <= frame_port;
      end else if (out_vld && ow.out_ready) begin
        out_vld <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rx.app_rx_dvld) begin
            frame_ip   <= rx.app_rx_srcip;
            frame_port <= rx.app_rx_srcport;
`ifdef RX_PACKER_HDR_EN
            state      <= HDR;
`else
            state      <= COLLECT;
`endif
          end
        end
`ifdef RX_PACKER_HDR_EN
        HDR: if (out_free) state <= COLLECT;
`endif
        COLLECT: begin
          if (take) begin
            if (word_done) begin
              idx <= '0;
              if (out_free) begin
                acc   <= '0;
                state <= rx.app_rx_eof ? IDLE : COLLECT;
              end else begin
                acc      <= nxt;
                acc_full <= 1'b1;
                state    <= HOLD;
              end
            end else begin
              acc <= nxt;
              idx <= idx + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_free) begin
            acc      <= '0;
            acc_full <= 1'b0;
            state    <= acc.last ? IDLE : COLLECT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Receive-core flush: held through reset, then two cycles per soft flush
  always_ff @(posedge app_clk) begin
    if (!app_rst_n) begin
      rx_rst_q   <= 1'b1;
      flush_left <= 1'b0;
    end else if (sw_flush) begin
      rx_rst_q   <= 1'b1;
      flush_left <= 1'b1;
    end else if (flush_left) begin
      rx_rst_q   <= 1'b1;
      flush_left <= 1'b0;
    end else begin
      rx_rst_q   <= 1'b0;
    end
  end

  always_ff @(posedge app_clk) begin
    if (!app_rst_n) ovr_prev <= 1'b0;
    else            ovr_prev <= rx.app_rx_overrun;
  end

  assign ow.out_data    = out_q.data;
  assign ow.out_keep    = out_q.keep;
  assign ow.out_last    = out_q.last;
  assign ow.out_err     = out_q.err;
  assign ow.out_valid   = out_vld;
  assign ow.out_srcip   = out_ip;
  assign ow.out_srcport = out_port;

  gbe_rx_stat_cnt #(.W(CNT_W), .SAT(1'b0)) u_good (
    .clk(app_clk), .rst_n(app_rst_n),
    .inc(out_vld && ow.out_ready && out_q.last && !out_q.err), .cnt(good_cnt));

  gbe_rx_stat_cnt #(.W(CNT_W), .SAT(1'b0)) u_bad (
    .clk(app_clk), .rst_n(app_rst_n),
    .inc(out_vld && ow.out_ready && out_q.last && out_q.err), .cnt(bad_cnt));

  gbe_rx_stat_cnt #(.W(OVR_W), .SAT(1'b1)) u_ovr (
    .clk(app_clk), .rst_n(app_rst_n),
    .inc(rx.app_rx_overrun && !ovr_prev), .cnt(ovr_cnt));

endmodule
